rs232_rx_fifo: RTL and testbench

RS232_RX_FIFO -- requirements
Module: rs232_rx_fifo

---
 rtl/rs232_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_rs232_rx_fifo.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_fifo.sv
// RS-232 receiver: 2-flop line synchroniser, selectable baud and parity, and a show-ahead receive FIFO.
// Framing, parity and overrun errors are sticky until clr_err.
module rs232_rx_fifo #(
    parameter int ClockFreq   = 50000000,
    parameter int BaudFast    = 115200,
    parameter int BaudSlow    = 19200,
    parameter int DataBits    = 8,
    parameter int BufNumSlots = 63
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fsel,
    input  logic [1:0]                   par_mode,
    input  logic                         rxd,
    input  logic                         rd,
    input  logic                         clr_err,
    output logic [7:0]                   data_out,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(BufNumSlots):0] count,
    output logic                         err_frame,
    output logic                         err_parity,
    output logic                         err_overrun
);
    localparam int TFast = ClockFreq / BaudFast;
    localparam int TSlow = ClockFreq / BaudSlow;
    localparam int TMax  = (TFast > TSlow) ? TFast : TSlow;
    localparam int TimW  = $clog2(TMax + 1);
    localparam int CntW  = $clog2(BufNumSlots) + 1;
    localparam int PtrW  = (BufNumSlots > 1) ? $clog2(BufNumSlots) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(BufNumSlots - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

    state_e              state_q;
    logic                rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic [TimW-1:0]     tim_q, period_q;
    logic [3:0]          bit_q;
    logic [DataBits-1:0] shift_q;
    logic [1:0]          par_q;
    logic                bad_par_q;
    logic                wr_q;
    logic [7:0]          wr_data_q;
    logic                err_frame_q, err_parity_q, err_overrun_q;
    logic                tick;

    // tim_q counts down the cycles to the next sample point; tick marks that sample edge.
    assign tick = (tim_q <= TimW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_s1_q     <= 1'b1;
            rxd_s2_q     <= 1'b1;
            rxd_s3_q     <= 1'b1;
            state_q      <= S_IDLE;
            tim_q        <= '0;
            period_q     <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= '0;
            bad_par_q    <= 1'b0;
            wr_q         <= 1'b0;
            wr_data_q    <= '0;
            err_frame_q  <= 1'b0;
            err_parity_q <= 1'b0;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
            wr_q     <= 1'b0;
            // NOTE: later non-blocking assignments win, so a flag set in the case below overrides this clear.
            if (clr_err) begin
                err_frame_q  <= 1'b0;
                err_parity_q <= 1'b0;
            end
            if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
                tim_q <= tick ? period_q : tim_q - TimW'(1);

            case (state_q)
                S_IDLE: begin
                    if (rxd_s3_q && !rxd_s2_q) begin
                        state_q  <= S_START;
                        period_q <= fsel ? TimW'(TFast) : TimW'(TSlow);
                        tim_q    <= fsel ? TimW'(TFast / 2) : TimW'(TSlow / 2);
                        par_q    <= par_mode;
                    end
                end
                S_START: begin
                    if (tick) begin
                        bit_q     <= '0;
                        bad_par_q <= 1'b0;
                        state_q   <= rxd_s2_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q <= {rxd_s2_q, shift_q[DataBits-1:1]};
                        if (bit_q == 4'(DataBits - 1))
                            state_q <= (^par_q) ? S_PARITY : S_STOP;
                        else
                            bit_q <= bit_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        // par_q[1] is set only for odd parity, which expects an odd total of ones.
                        if (^{shift_q, rxd_s2_q, par_q[1]}) begin
                            bad_par_q    <= 1'b1;
                            err_parity_q <= 1'b1;
                        end
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (rxd_s2_q) begin
                            state_q   <= S_IDLE;
                            wr_q      <= !bad_par_q;
                            wr_data_q <= 8'(shift_q);
                        end else begin
                            err_frame_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxd_s2_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [7:0]      mem [BufNumSlots];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_wr, do_rd;

    assign full  = (count_q == CntW'(BufNumSlots));
    assign empty = (count_q == '0);
    assign do_rd = rd && !empty;
    // A pop on the same edge frees the slot, so a write into a full FIFO is legal then.
    assign do_wr = wr_q && (!full || rd);

    always_comb begin
        count_d  = count_q + CntW'(do_wr) - CntW'(do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        if (do_rd) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (clr_err) err_overrun_q <= 1'b0;
            if (wr_q && full && !rd) err_overrun_q <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; gating with empty keeps data_out at 0 until a byte lands.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_q;
    end

    assign data_out    = empty ? 8'h00 : mem[rd_ptr_q];
    assign count       = count_q;
    assign err_frame   = err_frame_q;
    assign err_parity  = err_parity_q;
    assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: serial frames are driven on rxd, good bytes go to a scoreboard queue
// and are compared as they are popped. Baud rates are scaled (T=16 fast, T=32 slow) to keep runs short.
module tb_rs232_rx_fifo;
    localparam int ClockFreq = 50_000_000;
    localparam int BaudFast  = 3_125_000;
    localparam int BaudSlow  = 1_562_500;
    localparam int TF        = 16;
    localparam int TS        = 32;
    localparam int Slots     = 63;
    localparam logic [1:0] PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10, PAR_NONE2 = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n, fsel, rxd, rd, clr_err;
    logic [1:0] par_mode;
    logic [7:0] data_out;
    logic       empty, full, err_frame, err_parity, err_overrun;
    logic [$clog2(Slots):0] count;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int start_cyc = -1;
    int wr_offset = 156;
    logic [7:0] exp_q [$];

    rs232_rx_fifo #(
        .ClockFreq(ClockFreq), .BaudFast(BaudFast), .BaudSlow(BaudSlow),
        .DataBits(8), .BufNumSlots(Slots)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fsel(fsel), .par_mode(par_mode), .rxd(rxd), .rd(rd),
        .clr_err(clr_err), .data_out(data_out), .empty(empty), .full(full), .count(count),
        .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int t, input logic [1:0] pm,
                              input bit flip_par, input int stop_low);
        logic p;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        start_cyc = cyc;
        hold(t);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            hold(t);
        end
        if (pm == PAR_EVEN || pm == PAR_ODD) begin
            p = (^data) ^ (pm == PAR_ODD) ^ flip_par;
            rxd = p;
            hold(t);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            hold(stop_low * t);
        end
        rxd = 1'b1;
        hold(2 * t);
    endtask

    // Raises rd (or clr_err) across the edge that lies offset cycles after the current frame's start bit.
    task automatic pulse_at(input int offset, input bit on_clr);
        int guard = 0;
        while (start_cyc < 0 && guard < 100) begin
            hold(1);
            guard++;
        end
        while (cyc < start_cyc + offset - 1) hold(1);
        if (on_clr) clr_err = 1'b1;
        else        rd = 1'b1;
        hold(1);
        clr_err = 1'b0;
        rd      = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: data_out=%h with no byte expected", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            if (empty !== 1'b0 || data_out !== exp) begin
                errors++;
                $display("FAIL %s: data_out=%h empty=%b, expected data_out=%h empty=0", name, data_out, empty, exp);
            end
        end
        rd = 1'b1;
        hold(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rxd = 1'b1; rd = 1'b0; clr_err = 1'b0; fsel = 1'b1; par_mode = PAR_NONE;
        hold(4);
        checks++;
        if (count !== 7'd0 || {empty, full, err_frame, err_parity, err_overrun} !== 5'b10000 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: count=%0d ef/ff/fe/pe/oe=%b data_out=%h, expected 0 10000 00",
                     count, {empty, full, err_frame, err_parity, err_overrun}, data_out);
        end
        rst_n = 1'b1;
        hold(2);
        rd = 1'b1;
        hold(3);
        rd = 1'b0;
        checks++;
        if (count !== 7'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rd_while_empty: count=%0d empty=%b, expected 0 1", count, empty);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(8'hA5);
        start_cyc = -1;
        fork
            send_frame(8'hA5, TF, PAR_NONE, 1'b0, 0);
            begin : mon_blk
                int g = 0;
                while ((start_cyc < 0 || empty === 1'b1) && g <= 40 * TF) begin
                    hold(1);
                    g++;
                end
                checks++;
                if (g > 40 * TF) begin
                    errors++;
                    $display("FAIL basic_write_timeout: empty=%b, expected 0 within %0d cycles", empty, 40 * TF);
                end else begin
                    wr_offset = cyc - start_cyc;
                end
            end
        join
        checks++;
        if (count !== 7'd1 || {empty, full, err_frame, err_parity, err_overrun} !== 5'b00000) begin
            errors++;
            $display("FAIL basic_status: count=%0d flags=%b, expected 1 00000",
                     count, {empty, full, err_frame, err_parity, err_overrun});
        end
        pop_check("basic_data_a5");
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1;
        rxd = 1'b0;
        hold(4);
        rxd = 1'b1;
        hold(3 * TF);
        checks++;
        if (count !== 7'd0 || {err_frame, err_parity, err_overrun} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_ignored: count=%0d errs=%b, expected 0 000", count, {err_frame, err_parity, err_overrun});
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, TF, PAR_NONE, 1'b0, 0);
        pop_check("glitch_then_3c");
    endtask

    task automatic test_parity();
        par_mode = PAR_ODD;
        send_frame(8'h01, TF, PAR_ODD, 1'b1, 0);
        checks++;
        if (err_parity !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL parity_odd_bad: err_parity=%b count=%0d, expected 1 0", err_parity, count);
        end
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        checks++;
        if (err_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear: err_parity=%b, expected 0", err_parity);
        end
        exp_q.push_back(8'h07);
        send_frame(8'h07, TF, PAR_ODD, 1'b0, 0);
        pop_check("parity_odd_good");
        par_mode = PAR_EVEN;
        send_frame(8'h96, TF, PAR_EVEN, 1'b1, 0);
        checks++;
        if (err_parity !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL parity_even_bad: err_parity=%b count=%0d, expected 1 0", err_parity, count);
        end
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        exp_q.push_back(8'h96);
        send_frame(8'h96, TF, PAR_EVEN, 1'b0, 0);
        pop_check("parity_even_good");
        par_mode = PAR_NONE2;
        exp_q.push_back(8'h81);
        send_frame(8'h81, TF, PAR_NONE2, 1'b0, 0);
        checks++;
        if (err_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_mode11_none: err_parity=%b, expected 0", err_parity);
        end
        pop_check("parity_mode11_data");
        par_mode = PAR_NONE;
    endtask

    task automatic test_framing();
        send_frame(8'hF0, TF, PAR_NONE, 1'b0, 2);
        checks++;
        if (err_frame !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL framing_error: err_frame=%b count=%0d, expected 1 0", err_frame, count);
        end
        exp_q.push_back(8'h55);
        send_frame(8'h55, TF, PAR_NONE, 1'b0, 0);
        pop_check("framing_then_55");
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        checks++;
        if (err_frame !== 1'b0) begin
            errors++;
            $display("FAIL framing_clear: err_frame=%b, expected 0", err_frame);
        end
    endtask

    task automatic test_clear_priority();
        start_cyc = -1;
        fork
            send_frame(8'h0F, TF, PAR_NONE, 1'b0, 2);
            pulse_at(wr_offset - 1, 1'b1);
        join
        checks++;
        if (err_frame !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: err_frame=%b, expected 1", err_frame);
        end
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
    endtask

    task automatic test_slow_latch();
        fsel = 1'b0;
        par_mode = PAR_EVEN;
        exp_q.push_back(8'hC3);
        fork
            send_frame(8'hC3, TS, PAR_EVEN, 1'b0, 0);
            begin
                hold(3 * TS);
                fsel = 1'b1;
                par_mode = PAR_NONE;
            end
        join
        checks++;
        if (count !== 7'd1 || {err_frame, err_parity} !== 2'b00) begin
            errors++;
            $display("FAIL slow_latched: count=%0d errs=%b, expected 1 00", count, {err_frame, err_parity});
        end
        pop_check("slow_data_c3");
    endtask

    task automatic test_rd_write_empty();
        exp_q.push_back(8'h5A);
        start_cyc = -1;
        fork
            send_frame(8'h5A, TF, PAR_NONE, 1'b0, 0);
            pulse_at(wr_offset, 1'b0);
        join
        checks++;
        if (count !== 7'd1) begin
            errors++;
            $display("FAIL rd_write_empty: count=%0d, expected 1", count);
        end
        pop_check("rd_write_empty_data");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < Slots; i++) begin
            logic [7:0] b;
            b = 8'(i * 3 + 1);
            exp_q.push_back(b);
            send_frame(b, TF, PAR_NONE, 1'b0, 0);
        end
        checks++;
        if (count !== 7'd63 || full !== 1'b1 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d full=%b oe=%b, expected 63 1 0", count, full, err_overrun);
        end
        send_frame(8'hEE, TF, PAR_NONE, 1'b0, 0);
        checks++;
        if (err_overrun !== 1'b1 || count !== 7'd63 || data_out !== exp_q[0]) begin
            errors++;
            $display("FAIL overrun: oe=%b count=%0d data_out=%h, expected 1 63 %h", err_overrun, count, data_out, exp_q[0]);
        end
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        checks++;
        if (data_out !== exp_q[0]) begin
            errors++;
            $display("FAIL full_rd_write_head: data_out=%h, expected %h", data_out, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        start_cyc = -1;
        fork
            send_frame(8'h77, TF, PAR_NONE, 1'b0, 0);
            pulse_at(wr_offset, 1'b0);
        join
        checks++;
        if (count !== 7'd63 || full !== 1'b1 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_rd_write: count=%0d full=%b oe=%b, expected 63 1 0", count, full, err_overrun);
        end
        for (int i = 0; i < Slots; i++) pop_check("drain_wrap");
        checks++;
        if (count !== 7'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: count=%0d empty=%b, expected 0 1", count, empty);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_q.push_back(8'h11);
        send_frame(8'h11, TF, PAR_NONE, 1'b0, 0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, TF, PAR_NONE, 1'b0, 0);
        @(posedge clk);
        #1;
        rxd = 1'b0;
        hold(TF);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0];
            hold(TF);
        end
        rxd = 1'b1;
        rst_n = 1'b0;
        hold(2);
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (count !== 7'd0 || {empty, full, err_frame, err_parity, err_overrun} !== 5'b10000 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_frame: count=%0d flags=%b data_out=%h, expected 0 10000 00",
                     count, {empty, full, err_frame, err_parity, err_overrun}, data_out);
        end
        hold(12 * TF);
        checks++;
        if (count !== 7'd0) begin
            errors++;
            $display("FAIL reset_no_write: count=%0d, expected 0", count);
        end
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, TF, PAR_NONE, 1'b0, 0);
        checks++;
        if (count !== 7'd1) begin
            errors++;
            $display("FAIL after_reset_count: count=%0d, expected 1", count);
        end
        pop_check("after_reset_7e");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_framing();
        test_clear_priority();
        test_slow_latch();
        test_rd_write_empty();
        test_overflow();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
